// File: rtl/dxl_status_rx.sv
// Dynamixel protocol 1.0 status-packet parser: frames, checksums and publishes
// one validated record per good packet; bad, corrupted or stalled packets pulse an error.
module dxl_status_rx #(
  parameter int MAX_PARAMS     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int PCW            = $clog2(MAX_PARAMS + 1)
) (
  input  logic                    clk_in,
  input  logic                    _reset_in,
  input  logic [7:0]              rx_data_in,
  input  logic                    rx_data_valid_in,
  input  logic                    flush_in,
  output logic                    pkt_valid_out,
  output logic [7:0]              pkt_id_out,
  output logic [7:0]              pkt_error_out,
  output logic [PCW-1:0]          pkt_param_count_out,
  output logic [8*MAX_PARAMS-1:0] pkt_params_out,
  output logic                    crc_error_out,
  output logic                    len_error_out,
  output logic                    timeout_out,
  output logic                    busy_out,
  output logic [2:0]              state_dbg_out
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_HDR1, S_HDR2, S_ID, S_LEN, S_ERR, S_PARAM, S_CKSUM
  } state_t;

  state_t                  state;
  logic [7:0]              sum_q;
  logic [7:0]              id_q;
  logic [7:0]              err_q;
  logic [PCW-1:0]          n_q;
  logic [PCW-1:0]          idx_q;
  logic [8*MAX_PARAMS-1:0] work_q;
  logic [TW-1:0]           tmo_q;
  logic                    len_bad;

  // LEN is legal when 2 <= LEN <= MAX_PARAMS+2; compared in 9 bits to avoid wrap.
  assign len_bad       = (rx_data_in < 8'd2) || ({1'b0, rx_data_in} > 9'(MAX_PARAMS + 2));
  assign busy_out      = (state != S_HDR1);
  assign state_dbg_out = state;

  always_ff @(posedge clk_in or negedge _reset_in) begin
    if (!_reset_in) begin
      state               <= S_HDR1;
      sum_q               <= '0;
      id_q                <= '0;
      err_q               <= '0;
      n_q                 <= '0;
      idx_q               <= '0;
      work_q              <= '0;
      tmo_q               <= '0;
      pkt_valid_out       <= 1'b0;
      crc_error_out       <= 1'b0;
      len_error_out       <= 1'b0;
      timeout_out         <= 1'b0;
      pkt_id_out          <= '0;
      pkt_error_out       <= '0;
      pkt_param_count_out <= '0;
      pkt_params_out      <= '0;
    end else begin
      pkt_valid_out <= 1'b0;
      crc_error_out <= 1'b0;
      len_error_out <= 1'b0;
      timeout_out   <= 1'b0;
      if (flush_in) begin
        state <= S_HDR1;
        tmo_q <= '0;
        idx_q <= '0;
        sum_q <= '0;
      end else if (rx_data_valid_in) begin
        // An accepted byte always restarts the stall timer, even at terminal count.
        tmo_q <= '0;
        case (state)
          S_HDR1: if (rx_data_in == 8'hFF) state <= S_HDR2;
          S_HDR2: state <= (rx_data_in == 8'hFF) ? S_ID : S_HDR1;
          S_ID: begin
            if (rx_data_in != 8'hFF) begin
              id_q  <= rx_data_in;
              sum_q <= rx_data_in;
              state <= S_LEN;
            end
          end
          S_LEN: begin
            if (len_bad) begin
              len_error_out <= 1'b1;
              state         <= S_HDR1;
            end else begin
              n_q   <= PCW'(rx_data_in - 8'd2);
              sum_q <= sum_q + rx_data_in;
              state <= S_ERR;
            end
          end
          S_ERR: begin
            err_q <= rx_data_in;
            sum_q <= sum_q + rx_data_in;
            idx_q <= '0;
            state <= (n_q == '0) ? S_CKSUM : S_PARAM;
          end
          S_PARAM: begin
            for (int k = 0; k < MAX_PARAMS; k++) begin
              if (idx_q == PCW'(k)) work_q[8*k +: 8] <= rx_data_in;
            end
            sum_q <= sum_q + rx_data_in;
            idx_q <= idx_q + PCW'(1);
            if (idx_q == n_q - PCW'(1)) state <= S_CKSUM;
          end
          S_CKSUM: begin
            if (rx_data_in == ~sum_q) begin
              pkt_valid_out       <= 1'b1;
              pkt_id_out          <= id_q;
              pkt_error_out       <= err_q;
              pkt_param_count_out <= n_q;
              // Stale buffer bytes from longer earlier packets are masked off.
              for (int k = 0; k < MAX_PARAMS; k++) begin
                pkt_params_out[8*k +: 8] <= (PCW'(k) < n_q) ? work_q[8*k +: 8] : 8'h00;
              end
            end else begin
              crc_error_out <= 1'b1;
            end
            state <= S_HDR1;
          end
          default: state <= S_HDR1;
        endcase
      end else if (state != S_HDR1) begin
        if (tmo_q == TMO_LAST) begin
          timeout_out <= 1'b1;
          state       <= S_HDR1;
          tmo_q       <= '0;
        end else begin
          tmo_q <= tmo_q + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dxl_status_rx.sv
// Bench for dxl_status_rx: directed protocol cases plus randomized packets
// checked against a byte-level packet model kept in the bench.
module tb_dxl_status_rx;
  localparam int MAXP = 8;
  localparam int TMO  = 64;
  localparam int PCW  = $clog2(MAXP + 1);
  localparam int W    = 16 + PCW + 8 * MAXP;

  logic                clk_in = 1'b0;
  logic                _reset_in = 1'b0;
  logic [7:0]          rx_data_in = 8'h00;
  logic                rx_data_valid_in = 1'b0;
  logic                flush_in = 1'b0;
  logic                pkt_valid_out;
  logic [7:0]          pkt_id_out;
  logic [7:0]          pkt_error_out;
  logic [PCW-1:0]      pkt_param_count_out;
  logic [8*MAXP-1:0]   pkt_params_out;
  logic                crc_error_out;
  logic                len_error_out;
  logic                timeout_out;
  logic                busy_out;
  logic [2:0]          state_dbg_out;

  dxl_status_rx #(.MAX_PARAMS(MAXP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_in(clk_in), ._reset_in(_reset_in), .rx_data_in(rx_data_in),
    .rx_data_valid_in(rx_data_valid_in), .flush_in(flush_in),
    .pkt_valid_out(pkt_valid_out), .pkt_id_out(pkt_id_out), .pkt_error_out(pkt_error_out),
    .pkt_param_count_out(pkt_param_count_out), .pkt_params_out(pkt_params_out),
    .crc_error_out(crc_error_out), .len_error_out(len_error_out), .timeout_out(timeout_out),
    .busy_out(busy_out), .state_dbg_out(state_dbg_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- scoreboard / model state ----------------
  int pass_cnt = 0;
  int total_cnt = 0;
  int n_valid = 0, n_crc = 0, n_len = 0, n_tmo = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] cur_rec = '0;   // model's view of the last good packet
  logic [7:0]   pkt_q[$];
  logic [7:0]   prm[MAXP];

  always @(negedge clk_in) begin
    if (pkt_valid_out) begin
      n_valid++;
      got_q.push_back({pkt_id_out, pkt_error_out, pkt_param_count_out, pkt_params_out});
    end
    if (crc_error_out) n_crc++;
    if (len_error_out) n_len++;
    if (timeout_out)   n_tmo++;
  end

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    rx_data_in = b;
    rx_data_valid_in = 1'b1;
    @(negedge clk_in);
    rx_data_valid_in = 1'b0;
  endtask

  task automatic send_q(input int gap_max);
    for (int i = 0; i < pkt_q.size(); i++) begin
      send_byte(pkt_q[i]);
      if (i != pkt_q.size() - 1) repeat ($urandom_range(0, gap_max)) @(negedge clk_in);
    end
  endtask

  // Builds FF FF ID LEN ERR P.. CKSUM from the rules; good packets update the model.
  task automatic build_pkt(input logic [7:0] id, input logic [7:0] err, input int n, input bit corrupt);
    int s;
    logic [7:0] ck;
    logic [8*MAXP-1:0] pv;
    s = id + (n + 2) + err;
    pv = '0;
    for (int k = 0; k < n; k++) begin
      s += prm[k];
      pv[8*k +: 8] = prm[k];
    end
    ck = 8'(~s);
    if (corrupt) ck = ck ^ 8'($urandom_range(1, 255));
    pkt_q.delete();
    pkt_q.push_back(8'hFF); pkt_q.push_back(8'hFF);
    pkt_q.push_back(id); pkt_q.push_back(8'(n + 2)); pkt_q.push_back(err);
    for (int k = 0; k < n; k++) pkt_q.push_back(prm[k]);
    pkt_q.push_back(ck);
    if (!corrupt) begin
      cur_rec = {id, err, PCW'(n), pv};
      exp_q.push_back(cur_rec);
    end
  endtask

  task automatic load_ping();
    pkt_q = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00, 8'hFC};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    total_cnt++;
    if ({pkt_id_out, pkt_error_out, pkt_param_count_out, pkt_params_out} !== '0)
      $display("FAIL reset_data: got %h expected 0", {pkt_id_out, pkt_error_out, pkt_param_count_out, pkt_params_out});
    else pass_cnt++;
    total_cnt++;
    if ({pkt_valid_out, crc_error_out, len_error_out, timeout_out, busy_out} !== 5'b0)
      $display("FAIL reset_flags: got %b expected 00000", {pkt_valid_out, crc_error_out, len_error_out, timeout_out, busy_out});
    else pass_cnt++;
  endtask

  task automatic test_ping();
    int v0, e0;
    logic [W-1:0] want;
    v0 = n_valid; e0 = n_crc + n_len + n_tmo;
    want = {8'h01, 8'h00, PCW'(0), {(8*MAXP){1'b0}}};
    load_ping();
    send_q(0);
    total_cnt++;
    if (pkt_valid_out !== 1'b1) $display("FAIL ping_latency: got %b expected 1", pkt_valid_out);
    else pass_cnt++;
    @(negedge clk_in);
    total_cnt++;
    if (pkt_valid_out !== 1'b0 || busy_out !== 1'b0)
      $display("FAIL ping_pulse_busy: got valid=%b busy=%b expected 0/0", pkt_valid_out, busy_out);
    else pass_cnt++;
    total_cnt++;
    if ({pkt_id_out, pkt_error_out, pkt_param_count_out, pkt_params_out} !== want)
      $display("FAIL ping_data: got %h expected %h", {pkt_id_out, pkt_error_out, pkt_param_count_out, pkt_params_out}, want);
    else pass_cnt++;
    total_cnt++;
    if (n_valid - v0 != 1 || n_crc + n_len + n_tmo != e0)
      $display("FAIL ping_pulses: got valid=%0d err=%0d expected 1/0", n_valid - v0, n_crc + n_len + n_tmo - e0);
    else pass_cnt++;
    cur_rec = want;
    got_q.delete();
  endtask

  task automatic test_read_and_crc();
    int v0, c0;
    logic [W-1:0] want;
    want = {8'h01, 8'h00, PCW'(2), 48'h0, 16'h0220};
    pkt_q = '{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00, 8'h20, 8'h02, 8'hD8};
    send_q(0);
    @(negedge clk_in);
    total_cnt++;
    if ({pkt_id_out, pkt_error_out, pkt_param_count_out, pkt_params_out} !== want)
      $display("FAIL read_data: got %h expected %h", {pkt_id_out, pkt_error_out, pkt_param_count_out, pkt_params_out}, want);
    else pass_cnt++;
    cur_rec = want;
    got_q.delete();
    v0 = n_valid; c0 = n_crc;
    pkt_q = '{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00, 8'h20, 8'h02, 8'hD9};
    send_q(1);
    total_cnt++;
    if (crc_error_out !== 1'b1) $display("FAIL crc_latency: got %b expected 1", crc_error_out);
    else pass_cnt++;
    @(negedge clk_in);
    total_cnt++;
    if (n_crc - c0 != 1 || n_valid != v0)
      $display("FAIL crc_pulses: got crc=%0d valid=%0d expected 1/0", n_crc - c0, n_valid - v0);
    else pass_cnt++;
    total_cnt++;
    if ({pkt_id_out, pkt_error_out, pkt_param_count_out, pkt_params_out} !== cur_rec)
      $display("FAIL crc_hold: got %h expected %h", {pkt_id_out, pkt_error_out, pkt_param_count_out, pkt_params_out}, cur_rec);
    else pass_cnt++;
  endtask

  task automatic test_len();
    logic [7:0] lens[3];
    int l0, v0;
    lens = '{8'h0C, 8'h01, 8'h0B};
    for (int i = 0; i < 3; i++) begin
      l0 = n_len; v0 = n_valid;
      pkt_q = '{8'hFF, 8'hFF, 8'h05, 8'h00};
      pkt_q[3] = lens[i];
      send_q(0);
      total_cnt++;
      if (len_error_out !== 1'b1) $display("FAIL len_latency_%h: got %b expected 1", lens[i], len_error_out);
      else pass_cnt++;
      @(negedge clk_in);
      total_cnt++;
      if (n_len - l0 != 1 || n_valid != v0 || busy_out !== 1'b0)
        $display("FAIL len_err_%h: got len=%0d valid=%0d busy=%b expected 1/0/0", lens[i], n_len - l0, n_valid - v0, busy_out);
      else pass_cnt++;
    end
    // Largest legal packet: LEN = MAXP+2.
    for (int k = 0; k < MAXP; k++) prm[k] = 8'($urandom_range(0, 255));
    build_pkt(8'h07, 8'h21, MAXP, 1'b0);
    l0 = n_len;
    send_q(0);
    @(negedge clk_in);
    total_cnt++;
    if ({pkt_id_out, pkt_error_out, pkt_param_count_out, pkt_params_out} !== cur_rec || n_len != l0)
      $display("FAIL len_max: got %h expected %h", {pkt_id_out, pkt_error_out, pkt_param_count_out, pkt_params_out}, cur_rec);
    else pass_cnt++;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_sync();
    int v0;
    v0 = n_valid;
    pkt_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00, 8'hFC};
    send_q(0);
    @(negedge clk_in);
    cur_rec = {8'h01, 8'h00, PCW'(0), {(8*MAXP){1'b0}}};
    total_cnt++;
    if (n_valid - v0 != 1 || pkt_id_out !== 8'h01 || pkt_params_out !== '0)
      $display("FAIL sync_extra_ff: got valid=%0d id=%h expected 1/01", n_valid - v0, pkt_id_out);
    else pass_cnt++;
    got_q.delete();
  endtask

  task automatic test_timeout();
    int t0, v0;
    t0 = n_tmo;
    pkt_q = '{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00, 8'h20};
    send_q(0);
    repeat (TMO - 1) @(negedge clk_in);
    total_cnt++;
    if (timeout_out !== 1'b0 || busy_out !== 1'b1)
      $display("FAIL tmo_early: got tmo=%b busy=%b expected 0/1", timeout_out, busy_out);
    else pass_cnt++;
    @(negedge clk_in);
    total_cnt++;
    if (timeout_out !== 1'b1 || busy_out !== 1'b0)
      $display("FAIL tmo_fire: got tmo=%b busy=%b expected 1/0", timeout_out, busy_out);
    else pass_cnt++;
    v0 = n_valid;
    load_ping();
    send_q(2);
    @(negedge clk_in);
    total_cnt++;
    if (n_valid - v0 != 1 || n_tmo - t0 != 1 || pkt_id_out !== 8'h01 || pkt_param_count_out !== '0)
      $display("FAIL tmo_recover: got valid=%0d tmo=%0d id=%h expected 1/1/01", n_valid - v0, n_tmo - t0, pkt_id_out);
    else pass_cnt++;
    cur_rec = {8'h01, 8'h00, PCW'(0), {(8*MAXP){1'b0}}};
    got_q.delete();
  endtask

  task automatic test_timeout_edge();
    int t0, v0;
    t0 = n_tmo; v0 = n_valid;
    pkt_q = '{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00};
    send_q(0);
    repeat (TMO - 1) @(negedge clk_in);
    pkt_q = '{8'h20, 8'h02, 8'hD8};
    send_q(0);
    @(negedge clk_in);
    cur_rec = {8'h01, 8'h00, PCW'(2), 48'h0, 16'h0220};
    total_cnt++;
    if (n_tmo != t0 || n_valid - v0 != 1 ||
        {pkt_id_out, pkt_error_out, pkt_param_count_out, pkt_params_out} !== cur_rec)
      $display("FAIL tmo_terminal_byte: got tmo=%0d valid=%0d data=%h expected 0/1/%h", n_tmo - t0, n_valid - v0,
               {pkt_id_out, pkt_error_out, pkt_param_count_out, pkt_params_out}, cur_rec);
    else pass_cnt++;
    got_q.delete();
  endtask

  task automatic test_flush();
    int v0, e0;
    v0 = n_valid; e0 = n_crc + n_len + n_tmo;
    pkt_q = '{8'hFF, 8'hFF, 8'h01};
    send_q(0);
    rx_data_in = 8'h02; rx_data_valid_in = 1'b1; flush_in = 1'b1;
    @(negedge clk_in);
    rx_data_valid_in = 1'b0; flush_in = 1'b0;
    total_cnt++;
    if (busy_out !== 1'b0) $display("FAIL flush_idle: got busy=%b expected 0", busy_out);
    else pass_cnt++;
    load_ping();
    send_q(0);
    repeat (2) @(negedge clk_in);
    total_cnt++;
    if (n_valid - v0 != 1 || n_crc + n_len + n_tmo != e0)
      $display("FAIL flush_pulses: got valid=%0d err=%0d expected 1/0", n_valid - v0, n_crc + n_len + n_tmo - e0);
    else pass_cnt++;
    cur_rec = {8'h01, 8'h00, PCW'(0), {(8*MAXP){1'b0}}};
    got_q.delete();
  endtask

  task automatic test_random_back_to_back();
    int v0, c0, n, gap;
    bit corrupt;
    logic [W-1:0] e, g;
    for (int p = 0; p < 40; p++) begin
      n = $urandom_range(0, MAXP);
      corrupt = ($urandom_range(0, 3) == 0);
      gap = (p < 20) ? 0 : 3;
      for (int k = 0; k < MAXP; k++) prm[k] = 8'($urandom_range(0, 255));
      v0 = n_valid; c0 = n_crc;
      build_pkt(8'($urandom_range(0, 254)), 8'($urandom_range(0, 255)), n, corrupt);
      send_q(gap);
      @(negedge clk_in);
      total_cnt++;
      if (n_valid - v0 != (corrupt ? 0 : 1) || n_crc - c0 != (corrupt ? 1 : 0))
        $display("FAIL rand_pulses_%0d: got valid=%0d crc=%0d expected corrupt=%0d", p, n_valid - v0, n_crc - c0, corrupt);
      else pass_cnt++;
      total_cnt++;
      if ({pkt_id_out, pkt_error_out, pkt_param_count_out, pkt_params_out} !== cur_rec)
        $display("FAIL rand_data_%0d: got %h expected %h", p, {pkt_id_out, pkt_error_out, pkt_param_count_out, pkt_params_out}, cur_rec);
      else pass_cnt++;
      if (!corrupt) begin
        e = exp_q.pop_front();
        g = (got_q.size() > 0) ? got_q.pop_front() : '0;
        total_cnt++;
        if (g !== e) $display("FAIL rand_record_%0d: got %h expected %h", p, g, e);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_async_reset();
    pkt_q = '{8'hFF, 8'hFF, 8'h03, 8'h06, 8'h11, 8'hAA, 8'h55};
    send_q(0);
    #1 _reset_in = 1'b0;
    #1;
    total_cnt++;
    if ({pkt_id_out, pkt_error_out, pkt_param_count_out, pkt_params_out} !== '0 ||
        {pkt_valid_out, crc_error_out, len_error_out, timeout_out, busy_out} !== 5'b0)
      $display("FAIL async_reset: got data=%h flags=%b expected 0/00000",
               {pkt_id_out, pkt_error_out, pkt_param_count_out, pkt_params_out},
               {pkt_valid_out, crc_error_out, len_error_out, timeout_out, busy_out});
    else pass_cnt++;
    @(negedge clk_in);
    _reset_in = 1'b1;
    cur_rec = '0;
    @(negedge clk_in);
    load_ping();
    send_q(0);
    @(negedge clk_in);
    total_cnt++;
    if (pkt_id_out !== 8'h01 || busy_out !== 1'b0)
      $display("FAIL reset_recover: got id=%h busy=%b expected 01/0", pkt_id_out, busy_out);
    else pass_cnt++;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    repeat (3) @(negedge clk_in);
    _reset_in = 1'b1;
    @(negedge clk_in);
    test_reset();
    test_ping();
    test_read_and_crc();
    test_len();
    test_sync();
    test_timeout();
    test_timeout_edge();
    test_flush();
    test_random_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
